axi_demux_1xn_reg: RTL and testbench

AXI_DEMUX_1XN_REG -- requirements
Module: axi_demux_1xn_reg

---
 rtl/axi_ic_pkg.sv | 14 +
 rtl/axi_reg_slice.sv | 52 +++++
 rtl/axi_demux_1xn_reg.sv | 179 +++++++++++++++++
 tb/tb_axi_demux_1xn_reg.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ic_pkg.sv
// Shared types and default sizing for the AXI-stream style interconnect blocks.
// Holds the routing state enum used by the demultiplexer.
package axi_ic_pkg;

   localparam int unsigned AXI_IC_WIDTH   = 32;
   localparam int unsigned AXI_IC_NUM_OUT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUTE = 2'd1,
      DROP  = 2'd2
   } axi_ic_state_e;

endpackage

// File: rtl/axi_reg_slice.sv
// One-entry valid/ready register stage; a full entry is replaced in the same
// cycle it drains, so a stream passes at one beat per clock.
module axi_reg_slice
   import axi_ic_pkg::*;
#(
   parameter int unsigned W = AXI_IC_WIDTH + 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         s_valid_i,
   input  logic [W-1:0] s_data_i,
   output logic         s_ready_o,
   output logic         m_valid_o,
   output logic [W-1:0] m_data_o,
   input  logic         m_ready_i
);

   logic         full_q, full_d;
   logic [W-1:0] data_q, data_d;

   assign s_ready_o = !full_q || m_ready_i;
   assign m_valid_o = full_q;
   assign m_data_o  = data_q;

   // Next-state of the entry: load on push, clear on drain, else hold
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (s_valid_i && s_ready_o) begin
         full_d = 1'b1;
         data_d = s_data_i;
      end else if (m_ready_i) begin
         full_d = 1'b0;
         data_d = '0;
      end else begin
         full_d = full_q;
         data_d = data_q;
      end
   end

   // Entry register with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/axi_demux_1xn_reg.sv
// 1-to-N burst demultiplexer with one shared registered output stage.
// Define AXI_DEMUX_DECERR_EN to drop out-of-range selects and pulse dec_err.
module axi_demux_1xn_reg
   import axi_ic_pkg::*;
#(
   parameter int unsigned WIDTH   = AXI_IC_WIDTH,
   parameter int unsigned NUM_OUT = AXI_IC_NUM_OUT,
   parameter int unsigned SEL_W   = $clog2(NUM_OUT)
) (
   input  logic                     ACLK,
   input  logic                     ARESET,
   input  logic                     enable,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [SEL_W-1:0]         in_sel,
   input  logic                     in_valid,
   input  logic                     in_last,
   output logic                     in_ready,
   output logic [NUM_OUT*WIDTH-1:0] out_data,
   output logic [NUM_OUT-1:0]       out_valid,
   output logic [NUM_OUT-1:0]       out_last,
   input  logic [NUM_OUT-1:0]       out_ready,
   output logic                     busy
`ifdef AXI_DEMUX_DECERR_EN
   ,
   output logic                     dec_err
`endif
);

   axi_ic_state_e    state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] sel_first_s;
   logic             sel_ok_s;
   logic             ready_sel_s;
   logic             sl_ready_s;
   logic             sl_push_s;
   logic             sl_valid_s;
   logic [WIDTH:0]   sl_data_s;
   logic             in_ready_s;
`ifdef AXI_DEMUX_DECERR_EN
   logic             dec_err_q, dec_err_d;
`endif

   assign sel_ok_s = (32'(in_sel) < NUM_OUT);

`ifdef AXI_DEMUX_DECERR_EN
   assign sel_first_s = in_sel;
`else
   assign sel_first_s = sel_ok_s ? in_sel : SEL_W'(NUM_OUT - 1);
`endif

   // Ready of the channel that owns the output register (sel_q)
   always_comb begin
      ready_sel_s = 1'b0;
      for (int k = 0; k < NUM_OUT; k++) begin
         ready_sel_s = ready_sel_s | ((sel_q == SEL_W'(k)) & out_ready[k]);
      end
   end

   axi_reg_slice #(
      .W (WIDTH + 1)
   ) u_out_reg (
      .clk_i     (ACLK),
      .rst_i     (ARESET),
      .s_valid_i (sl_push_s),
      .s_data_i  ({in_last, in_data}),
      .s_ready_o (sl_ready_s),
      .m_valid_o (sl_valid_s),
      .m_data_o  (sl_data_s),
      .m_ready_i (ready_sel_s)
   );

   // Burst FSM: admission, channel lock and push into the output register
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      in_ready_s = 1'b0;
      sl_push_s  = 1'b0;
`ifdef AXI_DEMUX_DECERR_EN
      dec_err_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            // A held beat from the previous burst still belongs to sel_q here
            if (enable) begin
`ifdef AXI_DEMUX_DECERR_EN
               in_ready_s = sel_ok_s ? sl_ready_s : 1'b1;
`else
               in_ready_s = sl_ready_s;
`endif
            end else begin
               in_ready_s = 1'b0;
            end
            if (in_valid && in_ready_s) begin
`ifdef AXI_DEMUX_DECERR_EN
               if (sel_ok_s) begin
                  sel_d     = sel_first_s;
                  sl_push_s = 1'b1;
                  state_d   = in_last ? IDLE : ROUTE;
               end else begin
                  dec_err_d = in_last;
                  state_d   = in_last ? IDLE : DROP;
               end
`else
               sel_d     = sel_first_s;
               sl_push_s = 1'b1;
               state_d   = in_last ? IDLE : ROUTE;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         ROUTE: begin
            in_ready_s = sl_ready_s;
            if (in_valid && in_ready_s) begin
               sl_push_s = 1'b1;
               state_d   = in_last ? IDLE : ROUTE;
            end else begin
               state_d = ROUTE;
            end
         end
`ifdef AXI_DEMUX_DECERR_EN
         DROP: begin
            in_ready_s = 1'b1;
            if (in_valid && in_last) begin
               dec_err_d = 1'b1;
               state_d   = IDLE;
            end else begin
               state_d = DROP;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, channel lock and error pulse registers
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q   <= IDLE;
         sel_q     <= '0;
`ifdef AXI_DEMUX_DECERR_EN
         dec_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
`ifdef AXI_DEMUX_DECERR_EN
         dec_err_q <= dec_err_d;
`endif
      end
   end

   // Steer the output register onto the locked channel only
   always_comb begin
      out_valid = '0;
      out_last  = '0;
      out_data  = '0;
      for (int k = 0; k < NUM_OUT; k++) begin
         if (sel_q == SEL_W'(k)) begin
            out_valid[k]               = sl_valid_s;
            out_last[k]                = sl_valid_s & sl_data_s[WIDTH];
            out_data[k*WIDTH +: WIDTH] = sl_valid_s ? sl_data_s[WIDTH-1:0] : '0;
         end else begin
            out_valid[k]               = 1'b0;
            out_last[k]                = 1'b0;
            out_data[k*WIDTH +: WIDTH] = '0;
         end
      end
   end

   assign in_ready = in_ready_s & ~ARESET;
   assign busy     = (state_q != IDLE);
`ifdef AXI_DEMUX_DECERR_EN
   assign dec_err  = dec_err_q;
`endif

endmodule

// File: tb/tb_axi_demux_1xn_reg.sv
// Self-checking bench for axi_demux_1xn_reg: directed scenarios plus a random
// run against a queue-level model; a NUM_OUT=3 instance covers the decode case.
module tb_axi_demux_1xn_reg;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int SW = 2;
   localparam int N3 = 3;

   logic           ACLK = 1'b0;
   logic           ARESET;
   logic           enable, in_valid, in_last, in_ready, busy;
   logic [W-1:0]   in_data;
   logic [SW-1:0]  in_sel;
   logic [N*W-1:0] out_data;
   logic [N-1:0]   out_valid, out_last, out_ready;

   logic            d3_enable, d3_in_valid, d3_in_last, d3_in_ready, d3_busy;
   logic [W-1:0]    d3_in_data;
   logic [SW-1:0]   d3_in_sel;
   logic [N3*W-1:0] d3_out_data;
   logic [N3-1:0]   d3_out_valid, d3_out_last, d3_out_ready;
`ifdef AXI_DEMUX_DECERR_EN
   logic            dec_err, d3_dec_err;
`endif

   int total = 0;
   int bad   = 0;

   always #5 ACLK = ~ACLK;

   axi_demux_1xn_reg #(.WIDTH(W), .NUM_OUT(N), .SEL_W(SW)) dut (
      .ACLK(ACLK), .ARESET(ARESET), .enable(enable), .in_data(in_data),
      .in_sel(in_sel), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
      .out_ready(out_ready), .busy(busy)
`ifdef AXI_DEMUX_DECERR_EN
      , .dec_err(dec_err)
`endif
   );

   axi_demux_1xn_reg #(.WIDTH(W), .NUM_OUT(N3), .SEL_W(SW)) dut3 (
      .ACLK(ACLK), .ARESET(ARESET), .enable(d3_enable), .in_data(d3_in_data),
      .in_sel(d3_in_sel), .in_valid(d3_in_valid), .in_last(d3_in_last),
      .in_ready(d3_in_ready), .out_data(d3_out_data), .out_valid(d3_out_valid),
      .out_last(d3_out_last), .out_ready(d3_out_ready), .busy(d3_busy)
`ifdef AXI_DEMUX_DECERR_EN
      , .dec_err(d3_dec_err)
`endif
   );

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   function automatic logic [N*W-1:0] lane(input int ch, input logic [W-1:0] d);
      logic [N*W-1:0] v;
      v = '0;
      v[ch*W +: W] = d;
      return v;
   endfunction

   task automatic test_reset();
      ARESET = 1'b1; enable = 1'b1; in_valid = 1'b1; in_sel = 2'd2;
      in_data = 8'h5A; in_last = 1'b0; out_ready = '1;
      repeat (2) tick();
      @(negedge ACLK);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (out_valid !== '0 || out_last !== '0 || out_data !== '0) begin
         bad++; $display("FAIL reset_outputs valid=%b last=%b data=%h exp=0", out_valid, out_last, out_data);
      end
`ifdef AXI_DEMUX_DECERR_EN
      total++; if (dec_err !== 1'b0) begin bad++; $display("FAIL reset_dec_err got=%b exp=0", dec_err); end
`endif
      ARESET = 1'b0; in_valid = 1'b0; enable = 1'b0;
      tick();
   endtask

   task automatic test_burst();
      logic [W-1:0] d [3] = '{8'hA1, 8'hA2, 8'hA3};
      enable = 1'b1; out_ready = '1;
      for (int i = 0; i < 4; i++) begin
         if (i < 3) begin
            in_valid = 1'b1; in_data = d[i]; in_sel = (i == 0) ? 2'd2 : 2'd0; in_last = (i == 2);
         end else begin
            in_valid = 1'b0; in_last = 1'b0;
         end
         @(negedge ACLK);
         if (i < 3) begin
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL burst_in_ready beat=%0d got=%b exp=1", i, in_ready); end
         end
         if (i > 0) begin
            total++;
            if (out_valid !== 4'b0100 || out_data !== lane(2, d[i-1]) || out_last !== ((i == 3) ? 4'b0100 : 4'b0000)) begin
               bad++; $display("FAIL burst_out beat=%0d valid=%b data=%h last=%b exp_data=%h", i-1, out_valid, out_data, out_last, lane(2, d[i-1]));
            end
            total++; if (busy !== (i < 3)) begin bad++; $display("FAIL burst_busy beat=%0d got=%b exp=%b", i, busy, (i < 3)); end
         end
         tick();
      end
      @(negedge ACLK);
      total++; if (out_valid !== '0 || out_data !== '0) begin bad++; $display("FAIL burst_drained valid=%b data=%h exp=0", out_valid, out_data); end
      tick();
   endtask

   task automatic test_backpressure();
      logic [W-1:0] exp_q [$];
      int sent = 0;
      int got  = 0;
      bit exp_rdy, acc, pop;
      enable = 1'b1;
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
         out_ready = (cyc >= 1 && cyc <= 5) ? 4'b1101 : 4'b1111;
         in_valid  = (sent < 6);
         in_data   = 8'(48 + sent);
         in_last   = (sent == 5);
         in_sel    = (sent == 0) ? 2'd1 : 2'd2;
         @(negedge ACLK);
         exp_rdy = (exp_q.size() == 0) || out_ready[1];
         total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy); end
         total++;
         if (exp_q.size() > 0) begin
            if (out_valid !== 4'b0010 || out_data !== lane(1, exp_q[0])) begin
               bad++; $display("FAIL bp_out cyc=%0d valid=%b data=%h exp=%h", cyc, out_valid, out_data, lane(1, exp_q[0]));
            end
         end else if (out_valid !== '0) begin
            bad++; $display("FAIL bp_out cyc=%0d valid=%b exp=0", cyc, out_valid);
         end
         pop = (exp_q.size() > 0) && out_ready[1];
         acc = in_valid && exp_rdy;
         tick();
         if (pop) begin void'(exp_q.pop_front()); got++; end
         if (acc) begin exp_q.push_back(in_data); sent++; end
      end
      in_valid = 1'b0; in_last = 1'b0;
      total++; if (got != 6) begin bad++; $display("FAIL bp_count got=%0d exp=6", got); end
   endtask

   task automatic test_enable();
      enable = 1'b0; in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h11; in_last = 1'b0; out_ready = '1;
      repeat (3) begin
         @(negedge ACLK);
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL en_idle_ready got=%b exp=0", in_ready); end
         total++; if (busy !== 1'b0 || out_valid !== '0) begin bad++; $display("FAIL en_idle_state busy=%b valid=%b exp=0", busy, out_valid); end
         tick();
      end
      enable = 1'b1;
      @(negedge ACLK);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL en_first_ready got=%b exp=1", in_ready); end
      tick();
      enable = 1'b0; in_data = 8'h12; in_sel = 2'd0;
      @(negedge ACLK);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL en_mid_ready got=%b exp=1", in_ready); end
      total++; if (out_valid !== 4'b1000 || out_data !== lane(3, 8'h11)) begin bad++; $display("FAIL en_beat0 valid=%b data=%h", out_valid, out_data); end
      tick();
      in_data = 8'h13; in_last = 1'b1;
      @(negedge ACLK);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL en_last_ready got=%b exp=1", in_ready); end
      total++; if (out_valid !== 4'b1000 || out_data !== lane(3, 8'h12)) begin bad++; $display("FAIL en_beat1 valid=%b data=%h", out_valid, out_data); end
      tick();
      in_data = 8'h14; in_last = 1'b0;
      @(negedge ACLK);
      total++; if (in_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL en_after ready=%b busy=%b exp=0,0", in_ready, busy); end
      total++; if (out_valid !== 4'b1000 || out_last !== 4'b1000 || out_data !== lane(3, 8'h13)) begin
         bad++; $display("FAIL en_beat2 valid=%b last=%b data=%h", out_valid, out_last, out_data);
      end
      tick();
      in_valid = 1'b0;
      @(negedge ACLK);
      total++; if (out_valid !== '0) begin bad++; $display("FAIL en_drain valid=%b exp=0", out_valid); end
      tick();
   endtask

   task automatic test_sel_change();
      enable = 1'b1; out_ready = '1;
      for (int i = 0; i < 4; i++) begin
         in_valid = (i < 3); in_data = 8'(112 + i); in_sel = (i == 0) ? 2'd1 : 2'd3; in_last = (i == 2);
         @(negedge ACLK);
         if (i > 0) begin
            total++;
            if (out_valid !== 4'b0010 || out_data !== lane(1, 8'(112 + i - 1))) begin
               bad++; $display("FAIL selchg_out beat=%0d valid=%b data=%h exp=%h", i-1, out_valid, out_data, lane(1, 8'(112 + i - 1)));
            end
         end
         tick();
      end
      in_last = 1'b0;
   endtask

   task automatic test_reset_mid();
      enable = 1'b1; out_ready = 4'b1110; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hC5; in_last = 1'b0;
      @(negedge ACLK);
      tick();
      in_valid = 1'b0;
      @(negedge ACLK);
      total++; if (out_valid !== 4'b0001 || out_data !== lane(0, 8'hC5) || busy !== 1'b1) begin
         bad++; $display("FAIL rstmid_held valid=%b data=%h busy=%b", out_valid, out_data, busy);
      end
      ARESET = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
      tick();
      @(negedge ACLK);
      total++; if (out_valid !== '0 || out_data !== '0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         bad++; $display("FAIL rstmid_after valid=%b data=%h busy=%b ready=%b exp=0", out_valid, out_data, busy, in_ready);
      end
      ARESET = 1'b0; in_valid = 1'b0; out_ready = '1;
      tick();
      repeat (3) begin
         @(negedge ACLK);
         total++; if (out_valid !== '0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_stale valid=%b busy=%b exp=0", out_valid, busy); end
         tick();
      end
      in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h99; in_last = 1'b1;
      @(negedge ACLK);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_new_ready got=%b exp=1", in_ready); end
      tick();
      in_valid = 1'b0; in_last = 1'b0;
      @(negedge ACLK);
      total++; if (out_valid !== 4'b0100 || out_data !== lane(2, 8'h99) || out_last !== 4'b0100 || busy !== 1'b0) begin
         bad++; $display("FAIL rstmid_single valid=%b data=%h last=%b busy=%b", out_valid, out_data, out_last, busy);
      end
      tick();
   endtask

   task automatic test_decode();
      d3_enable = 1'b1; d3_out_ready = '1;
      for (int i = 0; i < 4; i++) begin
         d3_in_valid = (i < 2); d3_in_data = 8'(81 + i); d3_in_sel = 2'd3; d3_in_last = (i == 1);
         @(negedge ACLK);
         if (i < 2) begin
            total++; if (d3_in_ready !== 1'b1) begin bad++; $display("FAIL dec_in_ready beat=%0d got=%b exp=1", i, d3_in_ready); end
         end
         total++; if (d3_busy !== (i == 1)) begin bad++; $display("FAIL dec_busy cyc=%0d got=%b exp=%b", i, d3_busy, (i == 1)); end
`ifdef AXI_DEMUX_DECERR_EN
         total++; if (d3_out_valid !== '0) begin bad++; $display("FAIL dec_no_out cyc=%0d valid=%b exp=0", i, d3_out_valid); end
         total++; if (d3_dec_err !== (i == 2)) begin bad++; $display("FAIL dec_err cyc=%0d got=%b exp=%b", i, d3_dec_err, (i == 2)); end
`else
         if (i == 1 || i == 2) begin
            total++;
            if (d3_out_valid !== 3'b100 || d3_out_data !== {8'(81 + i - 1), 16'h0000} || d3_out_last !== ((i == 2) ? 3'b100 : 3'b000)) begin
               bad++; $display("FAIL dec_clamp cyc=%0d valid=%b data=%h last=%b", i, d3_out_valid, d3_out_data, d3_out_last);
            end
         end
`endif
         tick();
      end
      d3_enable = 1'b0; d3_in_last = 1'b0;
   endtask

   task automatic test_random();
      bit in_burst = 1'b0;
      int burst_ch = 0;
      bit held = 1'b0;
      int held_ch = 0;
      logic [W-1:0] held_d = '0;
      bit held_l = 1'b0;
      int rem = 0;
      bit pending = 1'b0;
      bit exp_rdy, acc, pop;
      logic [N*W-1:0] exp_data;
      logic [N-1:0] exp_v, exp_l;
      ARESET = 1'b1; in_valid = 1'b0; enable = 1'b0; in_last = 1'b0;
      tick();
      ARESET = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (!pending) begin
            if ($urandom_range(0, 3) != 0) begin
               if (rem == 0) rem = $urandom_range(1, 4);
               in_sel = SW'($urandom_range(0, 3));
               in_data = W'($urandom);
               in_last = (rem == 1);
               in_valid = 1'b1;
               pending = 1'b1;
            end else begin
               in_valid = 1'b0;
               in_last = 1'b0;
            end
         end
         enable = ($urandom_range(0, 9) < 7);
         out_ready = N'($urandom);
         @(negedge ACLK);
         exp_rdy = (in_burst || enable) && (!held || out_ready[held_ch]);
         exp_v = '0; exp_l = '0; exp_data = '0;
         if (held) begin
            exp_v[held_ch] = 1'b1; exp_l[held_ch] = held_l; exp_data[held_ch*W +: W] = held_d;
         end
         total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy); end
         total++; if (busy !== in_burst) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, in_burst); end
         total++; if (out_valid !== exp_v || out_last !== exp_l || out_data !== exp_data) begin
            bad++; $display("FAIL rnd_out cyc=%0d valid=%b/%b last=%b/%b data=%h/%h", cyc, out_valid, exp_v, out_last, exp_l, out_data, exp_data);
         end
         acc = in_valid && exp_rdy;
         pop = held && out_ready[held_ch];
         tick();
         if (pop) held = 1'b0;
         if (acc) begin
            if (!in_burst) burst_ch = int'(in_sel);
            held = 1'b1; held_ch = burst_ch; held_d = in_data; held_l = in_last;
            in_burst = !in_last;
            pending = 1'b0;
            rem--;
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      ARESET = 1'b1; enable = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      in_data = '0; in_sel = '0; out_ready = '0;
      d3_enable = 1'b0; d3_in_valid = 1'b0; d3_in_last = 1'b0;
      d3_in_data = '0; d3_in_sel = '0; d3_out_ready = '0;
      test_reset();
      test_burst();
      test_backpressure();
      test_enable();
      test_sel_change();
      test_reset_mid();
      test_decode();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
